// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package cdb_pkg;
  localparam int WIDTH      = 31;
  localparam int ROB        = 2;
  localparam int BRANCH_REQ = 0;
  localparam int ALU_REQ    = 1;

  typedef struct packed {
    logic [ROB:0]   rob;
    logic [WIDTH:0] value;
  } cdb_packet_t;

  function automatic int unsigned popcnt(input logic [31:0] v);
    popcnt = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) popcnt++;
  endfunction
endpackage

// File: rtl/cdb_if.sv
// Functional-unit <-> CDB arbiter bundle; master = requesting units, slave = arbiter.
interface cdb_if #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
);
  import cdb_pkg::*;

  logic                        clear;
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][WIDTH:0]    reqResult;
  logic [NREQ-1:0][ROB:0]      reqRob;
  logic [NREQ-1:0]             ready;
  logic [NREQ-1:0]             grant;
  logic                        validBroadcast;
  logic [WIDTH:0]              result;
  logic [ROB:0]                robEntry;
  logic [PTR_W+1:0]            pendingCount;

  modport master (
    output clear, req, reqResult, reqRob,
    input  ready, grant, validBroadcast, result, robEntry, pendingCount
  );
  modport slave (
    input  clear, req, reqResult, reqRob,
    output ready, grant, validBroadcast, result, robEntry, pendingCount
  );
endinterface

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: nearest candidate at or after ptr wins.
// CDB_BRANCH_PRIO_EN: the branch requester wins whenever it is a candidate.
module cdb_rr_pick
  import cdb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  i_cand,
  input  logic [PTR_W:0]   i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [PTR_W:0]   o_idx,
  output logic             o_any
);
  localparam int PW = PTR_W + 1;

  int w_best;
  int w_dist;

  always_comb begin
    o_idx  = '0;
    w_best = NREQ;
    w_dist = 0;
    // distance of each index from ptr going upward, modulo NREQ
    for (int i = 0; i < NREQ; i++) begin
      w_dist = i - int'(i_ptr);
      if (w_dist < 0) w_dist = w_dist + NREQ;
      if (i_cand[i] && w_dist < w_best) begin
        w_best = w_dist;
        o_idx  = PW'(i);
      end
    end
`ifdef CDB_BRANCH_PRIO_EN
    if (i_cand[BRANCH_REQ]) o_idx = PW'(BRANCH_REQ);
`else
`endif
    o_any = |i_cand;
    for (int i = 0; i < NREQ; i++)
      o_grant[i] = o_any && (o_idx == PW'(i));
  end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per requester, round-robin pick, registered bus.
// Optional CDB_BRANCH_PRIO_EN gives the branch unit absolute priority.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input logic   clk,
  input logic   globalReset,
  cdb_if.slave  cdb
);
  localparam int PW = PTR_W + 1;
  localparam int CW = PTR_W + 2;

  logic [NREQ-1:0]               r_held;
  cdb_packet_t [NREQ-1:0]        r_slot;
  logic [PTR_W:0]                r_ptr;
  logic                          r_vb;
  logic [WIDTH:0]                r_result;
  logic [ROB:0]                  r_rob;
  logic [CW-1:0]                 r_pend;

  logic [NREQ-1:0]               w_ready;
  logic [NREQ-1:0]               w_fresh;
  logic [NREQ-1:0]               w_cand;
  logic [NREQ-1:0]               w_grant;
  logic [NREQ-1:0]               w_held_nxt;
  logic [PTR_W:0]                w_idx;
  logic [PTR_W:0]                w_ptr_nxt;
  logic                          w_any;
  cdb_packet_t [NREQ-1:0]        w_pkt;
  cdb_packet_t                   w_win_pkt;

  // ready depends only on registered state and clear, never on req
  assign w_ready = ~r_held & {NREQ{~cdb.clear}};
  assign w_fresh = cdb.req & w_ready;
  assign w_cand  = r_held | w_fresh;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      assign w_pkt[gi] = r_held[gi] ? r_slot[gi] : {cdb.reqRob[gi], cdb.reqResult[gi]};

      // a fresh packet that loses parks in its slot
      always_ff @(posedge clk)
        if (w_fresh[gi] && !w_grant[gi])
          r_slot[gi] <= {cdb.reqRob[gi], cdb.reqResult[gi]};
    end
  endgenerate

  cdb_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .i_cand  (w_cand),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_win_pkt = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) w_win_pkt = w_pkt[i];
  end

  assign w_held_nxt = w_cand & ~w_grant;
  assign w_ptr_nxt  = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (globalReset) begin
      r_held   <= '0;
      r_ptr    <= '0;
      r_vb     <= 1'b0;
      r_result <= '0;
      r_rob    <= '0;
      r_pend   <= '0;
    end else if (cdb.clear) begin
      r_held <= '0;
      r_ptr  <= '0;
      r_vb   <= 1'b0;
      r_pend <= '0;
    end else begin
      r_held <= w_held_nxt;
      r_pend <= CW'(popcnt(32'(w_held_nxt)));
      r_vb   <= w_any;
      if (w_any) begin
        r_result <= w_win_pkt.value;
        r_rob    <= w_win_pkt.rob;
        r_ptr    <= w_ptr_nxt;
      end
    end
  end

  assign cdb.ready          = w_ready;
  assign cdb.grant          = cdb.clear ? '0 : w_grant;
  assign cdb.validBroadcast = r_vb;
  assign cdb.result         = r_result;
  assign cdb.robEntry       = r_rob;
  assign cdb.pendingCount   = r_pend;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: accepted packets queue per requester, expected winners queue per cycle.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clk = 1'b0;
  logic globalReset;
  always #5 clk = ~clk;

  cdb_if #(.NREQ(2), .PTR_W(1)) bus();

  cdb_arbiter #(.NREQ(2), .PTR_W(1)) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .cdb         (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  cdb_packet_t q0[$];
  cdb_packet_t q1[$];
  int          q_win[$];

  logic [31:0] d_v0, d_v1;
  logic [2:0]  d_r0, d_r1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic flush();
    q0.delete();
    q1.delete();
    q_win.delete();
  endtask

  task automatic scoreboard(input string tag);
    int          w;
    cdb_packet_t p;
    if (bus.validBroadcast === 1'b1) begin
      if (q_win.size() == 0) begin
        chk({tag, "_spurious_bcast"}, 1, 0);
        return;
      end
      w = q_win.pop_front();
      if (w == 0 && q0.size() > 0)      p = q0.pop_front();
      else if (w == 1 && q1.size() > 0) p = q1.pop_front();
      else begin
        chk({tag, "_sb_empty"}, w, 99);
        return;
      end
      chk({tag, "_result"}, bus.result, p.value);
      chk({tag, "_rob"}, bus.robEntry, p.rob);
    end
  endtask

  // one bus cycle: drive, check ready/grant, clock, check registered outputs
  task automatic cyc(input logic [1:0] want, input logic clr, input int win,
                     input logic exp_vb, input int exp_pend, input logic [1:0] exp_rdy,
                     input string tag);
    logic [1:0] acc;
    logic [1:0] egnt;
    bus.clear        = clr;
    bus.reqResult[0] = d_v0;
    bus.reqResult[1] = d_v1;
    bus.reqRob[0]    = d_r0;
    bus.reqRob[1]    = d_r1;
    bus.req          = 2'b00;
    #1;
    chk({tag, "_ready"}, bus.ready, exp_rdy);
    acc     = clr ? 2'b00 : (want & bus.ready);
    bus.req = clr ? want : acc;
    #1;
    egnt = (clr || win < 0) ? 2'b00 : 2'(1 << win);
    chk({tag, "_grant"}, bus.grant, egnt);
    if (acc[0]) q0.push_back('{rob: d_r0, value: d_v0});
    if (acc[1]) q1.push_back('{rob: d_r1, value: d_v1});
    if (win >= 0 && !clr) q_win.push_back(win);
    @(posedge clk);
    #1;
    bus.req   = 2'b00;
    bus.clear = 1'b0;
    if (clr) flush();
    chk({tag, "_vb"}, bus.validBroadcast, exp_vb);
    chk({tag, "_pend"}, bus.pendingCount, exp_pend);
    scoreboard(tag);
  endtask

  task automatic do_reset(input logic [1:0] rq, input logic clr, input string tag);
    globalReset = 1'b1;
    bus.clear   = clr;
    bus.req     = rq;
    @(posedge clk);
    #1;
    globalReset = 1'b0;
    bus.clear   = 1'b0;
    bus.req     = 2'b00;
    flush();
    #1;
    chk({tag, "_vb"}, bus.validBroadcast, 0);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_rob"}, bus.robEntry, 0);
    chk({tag, "_pend"}, bus.pendingCount, 0);
    chk({tag, "_ready"}, bus.ready, 2'b11);
    chk({tag, "_grant"}, bus.grant, 2'b00);
  endtask

  // requesters must only assert req while ready (clear cycles excepted)
  always @(posedge clk)
    if (globalReset === 1'b0 && bus.clear === 1'b0)
      chk("proto", bus.req & ~bus.ready, 2'b00);

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    globalReset   = 1'b1;
    bus.clear     = 1'b0;
    bus.req       = 2'b00;
    bus.reqResult = '0;
    bus.reqRob    = '0;
    d_v0 = '0; d_v1 = '0; d_r0 = '0; d_r1 = '0;
    @(posedge clk);
    do_reset(2'b00, 1'b0, "rst0");

    // uncontended ALU request
    d_v1 = 32'h5; d_r1 = 3'd3;
    cyc(2'b11 & 2'b10, 1'b0, 1, 1'b1, 0, 2'b11, "t1");

    // simultaneous requests, ptr=0: branch first, ALU parked one cycle
    d_v0 = 32'd10; d_r0 = 3'd1; d_v1 = 32'd20; d_r1 = 3'd2;
    cyc(2'b11, 1'b0, 0, 1'b1, 1, 2'b11, "t2a");
    cyc(2'b00, 1'b0, 1, 1'b1, 0, 2'b01, "t2b");

    // sustained contention
    for (int k = 0; k < 8; k++) begin
      d_v0 = 32'h100 + k; d_r0 = 3'(k);
      d_v1 = 32'h200 + k; d_r1 = 3'(k + 4);
`ifdef CDB_BRANCH_PRIO_EN
      cyc(2'b11, 1'b0, 0, 1'b1, 1, (k == 0) ? 2'b11 : 2'b01, "t3");
`else
      cyc(2'b11, 1'b0, k % 2, 1'b1, 1,
          (k == 0) ? 2'b11 : ((k % 2) ? 2'b01 : 2'b10), "t3");
`endif
    end
`ifdef CDB_BRANCH_PRIO_EN
    cyc(2'b00, 1'b0, 1, 1'b1, 0, 2'b01, "t3drain");
`else
    cyc(2'b00, 1'b0, 0, 1'b1, 0, 2'b10, "t3drain");
`endif

    // clear drops a parked ALU packet and a fresh branch request
    do_reset(2'b00, 1'b0, "rst1");
    d_v0 = 32'h30; d_r0 = 3'd5; d_v1 = 32'h40; d_r1 = 3'd6;
    cyc(2'b11, 1'b0, 0, 1'b1, 1, 2'b11, "t4a");
    cyc(2'b01, 1'b1, -1, 1'b0, 0, 2'b00, "t4clr");
    cyc(2'b00, 1'b0, -1, 1'b0, 0, 2'b11, "t4idle");
    cyc(2'b11, 1'b0, 0, 1'b1, 1, 2'b11, "t4ptr");

    // reset overrides clear and req while a packet is parked
    do_reset(2'b01, 1'b1, "t5");
    cyc(2'b00, 1'b0, -1, 1'b0, 0, 2'b11, "t5idle");

    // bus value holds through idle cycles
    d_v0 = 32'h7; d_r0 = 3'd4;
    cyc(2'b01, 1'b0, 0, 1'b1, 0, 2'b11, "t6");
    cyc(2'b00, 1'b0, -1, 1'b0, 0, 2'b11, "t6i1");
    cyc(2'b00, 1'b0, -1, 1'b0, 0, 2'b11, "t6i2");
    chk("t6_hold_result", bus.result, 32'h7);
    chk("t6_hold_rob", bus.robEntry, 3'd4);

    chk("sb_drained", q_win.size() + q0.size() + q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
